// File: rtl/sprite_pixel_sink.sv
// sprite_pixel_sink: clips and filters drawer pixels, queues them in a FIFO
// and writes them to a framebuffer port that may stall.
module sprite_pixel_sink #(
   parameter int SCREEN_W = 160,
   parameter int SCREEN_H = 120,
   parameter int ADDR_W = 15,
   parameter int FIFO_DEPTH = 16,
   parameter bit TRANSPARENT_EN = 1'b1,
   parameter logic [2:0] TRANSPARENT_COLOR = 3'b000
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              plot,
   input  logic [9:0]        x_pix,
   input  logic [9:0]        y_pix,
   input  logic [2:0]        color,
   input  logic              fb_ready,
   output logic              fb_we,
   output logic [ADDR_W-1:0] fb_addr,
   output logic [2:0]        fb_data,
   output logic              fifo_full,
   output logic              busy,
   output logic              overflow,
   output logic [7:0]        clip_count
);
   localparam int PW = $clog2(FIFO_DEPTH);
   typedef enum logic {IDLE, WRITE} state_t;
   state_t state, state_nxt;
   logic pass, s1_valid, push, pop, empty;
   logic [ADDR_W-1:0] addr, s1_addr;
   logic [2:0] s1_data;
   logic [ADDR_W+2:0] mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [PW:0] count;
   always_comb begin
      pass = plot && 32'(x_pix) < SCREEN_W && 32'(y_pix) < SCREEN_H &&
             !(TRANSPARENT_EN && color == TRANSPARENT_COLOR);
      // 160 = 128 + 32, so the default screen width needs no multiplier
      addr = (SCREEN_W == 160) ?
             ADDR_W'({y_pix, 7'd0}) + ADDR_W'({y_pix, 5'd0}) + ADDR_W'(x_pix) :
             ADDR_W'(32'(y_pix) * SCREEN_W + 32'(x_pix));
   end
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         s1_valid   <= 1'b0;
         s1_addr    <= '0;
         s1_data    <= '0;
         clip_count <= '0;
      end else begin
         s1_valid <= pass;
         s1_addr  <= addr;
         s1_data  <= color;
         if (plot && !pass && clip_count != 8'hFF) clip_count <= clip_count + 8'd1;
      end
   assign empty     = count == '0;
   assign fifo_full = count == (PW+1)'(FIFO_DEPTH);
   assign pop       = !empty && (state == IDLE || fb_ready);
   // a full FIFO still accepts when the head leaves in the same cycle
   assign push      = s1_valid && (!fifo_full || pop);
   always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= {s1_addr, s1_data};
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop) rd_ptr <= rd_ptr + PW'(1);
         count <= count + (PW+1)'(push) - (PW+1)'(pop);
         if (s1_valid && !push) overflow <= 1'b1;
      end
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         state   <= IDLE;
         fb_addr <= '0;
         fb_data <= '0;
      end else begin
         state <= state_nxt;
         if (pop) {fb_addr, fb_data} <= mem[rd_ptr];
      end
   always_comb begin
      state_nxt = (state == IDLE) ? (empty ? IDLE : WRITE) :
                  ((fb_ready && empty) ? IDLE : WRITE);
   end
   assign fb_we = state == WRITE;
   assign busy  = s1_valid || !empty || state == WRITE;
endmodule

// File: tb/tb_sprite_pixel_sink.sv
// tb_sprite_pixel_sink: scoreboard bench for sprite_pixel_sink; expected
// framebuffer writes are queued as pixels are driven and popped on each write.
module tb_sprite_pixel_sink;
   localparam int ADDR_W = 15;
   logic clk = 1'b0, reset_n = 1'b0, plot = 1'b0, fb_ready = 1'b1;
   logic [9:0] x_pix = '0, y_pix = '0;
   logic [2:0] color = '0;
   logic fb_we, fifo_full, busy, overflow;
   logic [ADDR_W-1:0] fb_addr;
   logic [2:0] fb_data;
   logic [7:0] clip_count;
   logic nt_we, nt_full, nt_busy, nt_ovf;
   logic [ADDR_W-1:0] nt_addr;
   logic [2:0] nt_data;
   logic [7:0] nt_clip;
   int checks = 0, errors = 0, cyc = 0, writes = 0, nt_writes = 0, gaps = 0;
   int last_wcyc = -10;
   logic [ADDR_W-1:0] last_addr;
   logic [ADDR_W+2:0] sb[$];
   logic [ADDR_W+2:0] held_val, exp_v;
   bit held = 0;

   sprite_pixel_sink dut (
      .clk(clk), .reset_n(reset_n), .plot(plot), .x_pix(x_pix), .y_pix(y_pix),
      .color(color), .fb_ready(fb_ready), .fb_we(fb_we), .fb_addr(fb_addr),
      .fb_data(fb_data), .fifo_full(fifo_full), .busy(busy), .overflow(overflow),
      .clip_count(clip_count)
   );

   sprite_pixel_sink #(.TRANSPARENT_EN(1'b0)) dut_nt (
      .clk(clk), .reset_n(reset_n), .plot(plot), .x_pix(x_pix), .y_pix(y_pix),
      .color(color), .fb_ready(fb_ready), .fb_we(nt_we), .fb_addr(nt_addr),
      .fb_data(nt_data), .fifo_full(nt_full), .busy(nt_busy), .overflow(nt_ovf),
      .clip_count(nt_clip)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!reset_n) held = 0;
      else begin
         if (held) begin
            checks++;
            if (fb_we !== 1'b1 || {fb_addr, fb_data} !== held_val) begin
               errors++;
               $display("FAIL stall_hold: got we=%b addr=%0d data=%0d, want we=1 addr=%0d data=%0d",
                        fb_we, fb_addr, fb_data, held_val[ADDR_W+2:3], held_val[2:0]);
            end
         end
         held = fb_we && !fb_ready;
         held_val = {fb_addr, fb_data};
         if (fb_we && fb_ready) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL unexpected_write: got addr=%0d data=%0d, want no write", fb_addr, fb_data);
            end else begin
               exp_v = sb.pop_front();
               if ({fb_addr, fb_data} !== exp_v) begin
                  errors++;
                  $display("FAIL write_data: got addr=%0d data=%0d, want addr=%0d data=%0d",
                           fb_addr, fb_data, exp_v[ADDR_W+2:3], exp_v[2:0]);
               end
            end
            if (last_wcyc + 1 != cyc) gaps++;
            last_wcyc = cyc;
            last_addr = fb_addr;
            writes++;
         end
      end
   end

   always @(negedge clk) if (reset_n && nt_we && fb_ready) nt_writes++;

   task automatic put(input int x, input int y, input logic [2:0] c, input bit keep);
      @(posedge clk); #1;
      plot = 1'b1;
      x_pix = 10'(x);
      y_pix = 10'(y);
      color = c;
      if (keep && x < 160 && y < 120 && c != 3'b000) sb.push_back({ADDR_W'(y * 160 + x), c});
   endtask

   task automatic idle();
      @(posedge clk); #1;
      plot = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({fb_we, fb_addr, fb_data, fifo_full, busy, overflow, clip_count} !== '0) begin
         errors++;
         $display("FAIL reset_values: got we=%b addr=%0d data=%0d full=%b busy=%b ovf=%b clip=%0d, want all 0",
                  fb_we, fb_addr, fb_data, fifo_full, busy, overflow, clip_count);
      end
      @(posedge clk); #1;
      reset_n = 1'b1;
   endtask

   task automatic test_single();
      int c0;
      put(5, 2, 3'b101, 1);
      c0 = cyc;
      idle();
      repeat (2) @(negedge clk);
      checks++;
      if (fb_we !== 1'b0) begin
         errors++;
         $display("FAIL single_early: got we=%b at +2, want 0", fb_we);
      end
      @(negedge clk);
      checks++;
      if (fb_we !== 1'b1 || fb_addr !== ADDR_W'(325) || fb_data !== 3'd5) begin
         errors++;
         $display("FAIL single_latency: got we=%b addr=%0d data=%0d at +3, want we=1 addr=325 data=5",
                  fb_we, fb_addr, fb_data);
      end
      @(negedge clk);
      checks++;
      if (fb_we !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL single_done: got we=%b busy=%b at +4, want 0 0", fb_we, busy);
      end
      checks++;
      if (last_wcyc - c0 != 3) begin
         errors++;
         $display("FAIL single_cycle: got write at +%0d, want +3", last_wcyc - c0);
      end
   endtask

   task automatic test_burst();
      int w0 = writes, g0 = gaps;
      for (int yy = 50; yy <= 80; yy++)
         for (int xx = 100; xx <= 130; xx++) put(xx, yy, 3'b010, 1);
      idle();
      repeat (10) @(negedge clk);
      checks++;
      if (writes - w0 != 961 || gaps - g0 != 1) begin
         errors++;
         $display("FAIL burst_count: got %0d writes %0d gaps, want 961 writes 1 gap", writes - w0, gaps - g0);
      end
      checks++;
      if (last_addr !== ADDR_W'(12930) || overflow !== 1'b0 || sb.size() != 0) begin
         errors++;
         $display("FAIL burst_end: got last=%0d ovf=%b pending=%0d, want 12930 0 0",
                  last_addr, overflow, sb.size());
      end
   endtask

   task automatic test_clip();
      int w0 = writes;
      logic [7:0] cl0 = clip_count;
      put(159, 119, 3'b001, 1);
      put(160, 0, 3'b001, 1);
      put(0, 120, 3'b001, 1);
      idle();
      repeat (8) @(negedge clk);
      checks++;
      if (writes - w0 != 1 || last_addr !== ADDR_W'(19199)) begin
         errors++;
         $display("FAIL clip_write: got %0d writes last=%0d, want 1 write addr 19199", writes - w0, last_addr);
      end
      checks++;
      if (clip_count !== cl0 + 8'd2) begin
         errors++;
         $display("FAIL clip_count: got %0d, want %0d", clip_count, cl0 + 8'd2);
      end
   endtask

   task automatic test_transparent();
      int w0 = writes, n0 = nt_writes;
      logic [7:0] cl0 = clip_count;
      for (int i = 0; i < 10; i++) put(i, 3, 3'b000, 1);
      idle();
      repeat (8) @(negedge clk);
      checks++;
      if (writes != w0 || clip_count !== cl0 + 8'd10) begin
         errors++;
         $display("FAIL transparent_drop: got %0d writes clip=%0d, want 0 writes clip=%0d",
                  writes - w0, clip_count, cl0 + 8'd10);
      end
      checks++;
      if (nt_writes - n0 != 10) begin
         errors++;
         $display("FAIL transparent_off: got %0d writes, want 10", nt_writes - n0);
      end
   endtask

   task automatic test_stall();
      int w0 = writes;
      @(posedge clk); #1;
      fb_ready = 1'b0;
      for (int i = 0; i < 20; i++) put(i, 10, 3'b011, i < 17);
      idle();
      repeat (3) @(negedge clk);
      checks++;
      if (fifo_full !== 1'b1 || overflow !== 1'b1) begin
         errors++;
         $display("FAIL stall_full: got full=%b ovf=%b, want 1 1", fifo_full, overflow);
      end
      checks++;
      if (fb_we !== 1'b1 || fb_addr !== ADDR_W'(1600) || fb_data !== 3'd3) begin
         errors++;
         $display("FAIL stall_head: got we=%b addr=%0d data=%0d, want 1 1600 3", fb_we, fb_addr, fb_data);
      end
      @(posedge clk); #1;
      fb_ready = 1'b1;
      repeat (25) @(negedge clk);
      checks++;
      if (writes - w0 != 17 || sb.size() != 0 || fifo_full !== 1'b0) begin
         errors++;
         $display("FAIL stall_drain: got %0d writes pending=%0d full=%b, want 17 0 0",
                  writes - w0, sb.size(), fifo_full);
      end
   endtask

   task automatic test_reset_mid();
      int w0;
      @(posedge clk); #1;
      fb_ready = 1'b0;
      for (int i = 0; i < 9; i++) put(i, 20, 3'b110, 1);
      idle();
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b1 || fb_we !== 1'b1) begin
         errors++;
         $display("FAIL mid_loaded: got busy=%b we=%b, want 1 1", busy, fb_we);
      end
      reset_n = 1'b0;
      #1;
      checks++;
      if ({fb_we, fb_addr, fb_data, fifo_full, busy, overflow, clip_count} !== '0) begin
         errors++;
         $display("FAIL mid_reset: got we=%b addr=%0d data=%0d full=%b busy=%b ovf=%b clip=%0d, want all 0",
                  fb_we, fb_addr, fb_data, fifo_full, busy, overflow, clip_count);
      end
      sb.delete();
      @(posedge clk); #1;
      reset_n = 1'b1;
      fb_ready = 1'b1;
      w0 = writes;
      repeat (20) @(negedge clk);
      checks++;
      if (writes != w0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL mid_after: got %0d writes busy=%b, want 0 0", writes - w0, busy);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_burst();
      test_clip();
      test_transparent();
      test_stall();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/sprite_pixel_sink.md
Name: sprite_pixel_sink

Overview:
- Receiving end of the sprite-draw pixel stream. It takes the per-cycle x, y, colour and write-enable output of a sprite drawer and commits each pixel to the framebuffer write port.
- Clips pixels that fall off-screen and can drop a transparent colour.
- Buffers pixels in a small FIFO, because the framebuffer port may stall (fb_ready low) while the drawer cannot be back-pressured.
- Sits between the draw_* blocks and the VGA framebuffer memory.

Parameters:
- SCREEN_W, 160, visible columns; x >= SCREEN_W is clipped.
- SCREEN_H, 120, visible rows; y >= SCREEN_H is clipped.
- ADDR_W, 15, framebuffer address width; must satisfy SCREEN_W*SCREEN_H <= 2^ADDR_W.
- FIFO_DEPTH, 16, pixel FIFO entries; power of two, >= 2.
- TRANSPARENT_EN, 1, when 1, pixels whose colour equals TRANSPARENT_COLOR are dropped.
- TRANSPARENT_COLOR, 3'b000, colour treated as transparent.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- plot  in  1  pixel valid from the drawer; one pixel per cycle while high.
- x_pix  in  10  pixel column.
- y_pix  in  10  pixel row.
- color  in  3  pixel colour.
- fb_ready  in  1  framebuffer port can accept a write this cycle.
- fb_we  out  1  framebuffer write strobe; one pixel per high cycle.
- fb_addr  out  ADDR_W  linear address y*SCREEN_W + x.
- fb_data  out  3  pixel colour.
- fifo_full  out  1  FIFO occupancy == FIFO_DEPTH.
- busy  out  1  any pixel in the input stage, the FIFO or the output register.
- overflow  out  1  sticky; set when an accepted pixel found the FIFO full.
- clip_count  out  8  saturating count of clipped or transparent pixels.

Behaviour:
- Reset values (async, reset_n low): fb_we=0, fb_addr=0, fb_data=0, fifo_full=0, busy=0, overflow=0, clip_count=0. FIFO pointers and count are 0 and the input stage is invalid.
- Reset mid-stream: all buffered pixels are discarded and nothing is written after reset asserts.

Stage 1 (input register, every cycle):
- s1_valid <= plot && x_pix < SCREEN_W && y_pix < SCREEN_H && !(TRANSPARENT_EN && color == TRANSPARENT_COLOR).
- Address is computed here: addr = (y_pix<<7) + (y_pix<<5) + x_pix when SCREEN_W=160; generic y*SCREEN_W + x otherwise. The result is truncated to ADDR_W.
- plot high with s1_valid false -> clip_count += 1, saturating at 255.

FIFO:
- Push when s1_valid. Pop when the output stage takes an entry.
- Push and pop in the same cycle: count unchanged, push allowed even if full.
- Push while full with no pop: the pixel is dropped, overflow <= 1 (sticky until reset), and FIFO contents are unchanged.
- Pointers wrap modulo FIFO_DEPTH.

Output stage:
- FSM with two states, IDLE and WRITE.
- IDLE: FIFO non-empty -> pop the head into the output register and go to WRITE. fb_we is high the following cycle with the popped addr/data.
- WRITE: fb_we=1 is held with stable addr/data until sampled with fb_ready=1.
  - fb_ready=1 and FIFO non-empty -> pop the next entry the same cycle (back-to-back writes, one per cycle) and stay in WRITE.
  - fb_ready=1 and FIFO empty -> fb_we <= 0 and go to IDLE.
  - fb_ready=0 -> hold everything.
- Latency: plot at cycle N with an empty pipeline and fb_ready=1 -> fb_we high at N+3. Sustained throughput is 1 pixel/cycle while fb_ready=1.
- busy = s1_valid || FIFO count != 0 || state == WRITE.
- fb_addr/fb_data change only on a pop; never while fb_we=1 and fb_ready=0.

Test Plan:
- Single pixel x=5, y=2, color=3'b101, fb_ready=1 -> exactly one fb_we pulse 3 cycles later with fb_addr=325, fb_data=5; busy falls the next cycle.
- 31x31 sprite burst at (100,50), color 3'b010, fb_ready=1 -> 961 writes, in order, with no gaps after the first. Last fb_addr = 80*160+130 = 12930. overflow=0.
- Clipping: plot at (159,119) -> addr 19199 written. Plots at (160,0) and (0,120) -> no write, clip_count=2.
- Transparency: 10 pixels with color=0 and TRANSPARENT_EN=1 -> no fb_we, clip_count=10. Repeat with TRANSPARENT_EN=0 -> 10 writes.
- Stall: fb_ready=0 during a 20-pixel burst -> fifo_full asserts and overflow=1. After fb_ready=1, exactly the first FIFO_DEPTH+1 accepted pixels are written in order, with addr/data held stable during the stall.
- Reset asserted mid-burst with 8 pixels queued -> outputs reach reset values immediately. After release there are no fb_we pulses and busy=0.
